// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two operation request channels plus
// the shared result/response channel.
interface alu_arbiter_if #(
  parameter int WORD_SIZE = 8
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [WORD_SIZE-1:0] req0_a;
  logic [WORD_SIZE-1:0] req0_b;
  logic                 req0_mode;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [WORD_SIZE-1:0] req1_a;
  logic [WORD_SIZE-1:0] req1_b;
  logic                 req1_mode;
  logic                 resp0_valid;
  logic                 resp0_ready;
  logic                 resp1_valid;
  logic                 resp1_ready;
  logic [WORD_SIZE-1:0] resp_c;
  logic                 resp_overflow;

  modport master (
    output req0_valid, req0_a, req0_b, req0_mode,
    output req1_valid, req1_a, req1_b, req1_mode,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_c, resp_overflow
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_mode,
    input  req1_valid, req1_a, req1_b, req1_mode,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_c, resp_overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for the shared add/sub ALU: accepts one op at a
// time, drives the ALU from registers, and returns the captured result to its owner.
module alu_arbiter #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_arbiter_if.slave         bus,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic                 alu_mode,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic                 alu_overflow,
  output logic                 busy,
  output logic [7:0]           ovf_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 owner_q, owner_d;
  logic [WORD_SIZE-1:0] alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0] alu_b_q, alu_b_d;
  logic                 alu_mode_q, alu_mode_d;
  logic [WORD_SIZE-1:0] resp_c_q, resp_c_d;
  logic                 resp_ovf_q, resp_ovf_d;
  logic [7:0]           ovf_count_q, ovf_count_d;
  logic [1:0]           resp_valid_q, resp_valid_d;
  logic                 busy_q, busy_d;

  logic                 grant;
  logic                 grant_vld;
  logic                 ready0;
  logic                 ready1;
  logic                 owner_resp_ready;

  // Arbitration: on contention the requester not served last time wins.
  always_comb begin
    grant     = 1'b0;
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req0_valid) begin
      grant = 1'b0;
    end else begin
      grant = 1'b1;
    end
    ready0 = (state_q == IDLE) && grant_vld && (grant == 1'b0) && !rst;
    ready1 = (state_q == IDLE) && grant_vld && (grant == 1'b1) && !rst;
    owner_resp_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_mode_d   = alu_mode_q;
    resp_c_d     = resp_c_q;
    resp_ovf_d   = resp_ovf_q;
    ovf_count_d  = ovf_count_q;
    case (state_q)
      IDLE: begin
        if (ready0 || ready1) begin
          alu_a_d      = grant ? bus.req1_a : bus.req0_a;
          alu_b_d      = grant ? bus.req1_b : bus.req0_b;
          alu_mode_d   = grant ? bus.req1_mode : bus.req0_mode;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        resp_c_d   = alu_c;
        resp_ovf_d = alu_overflow;
        if (alu_overflow && (ovf_count_q != 8'hFF)) begin
          ovf_count_d = ovf_count_q + 8'd1;
        end else begin
          ovf_count_d = ovf_count_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status outputs are registered, so derive them from the next state.
    busy_d          = (state_d != IDLE);
    resp_valid_d[0] = (state_d == RESP) && (owner_d == 1'b0);
    resp_valid_d[1] = (state_d == RESP) && (owner_d == 1'b1);
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_mode_q   <= 1'b0;
      resp_c_q     <= '0;
      resp_ovf_q   <= 1'b0;
      ovf_count_q  <= 8'd0;
      resp_valid_q <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_mode_q   <= alu_mode_d;
      resp_c_q     <= resp_c_d;
      resp_ovf_q   <= resp_ovf_d;
      ovf_count_q  <= ovf_count_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.resp0_valid   = resp_valid_q[0];
  assign bus.resp1_valid   = resp_valid_q[1];
  assign bus.resp_c        = resp_c_q;
  assign bus.resp_overflow = resp_ovf_q;
  assign alu_a             = alu_a_q;
  assign alu_b             = alu_b_q;
  assign alu_mode          = alu_mode_q;
  assign busy              = busy_q;
  assign ovf_count         = ovf_count_q;

endmodule
